// File: rtl/seg7_pkg.sv
// Shared types and segment constants for the 7-segment display driver.
package seg7_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_UPDATE
    } state_t;

    localparam int unsigned BCD_DIGITS = 5;
    localparam logic [6:0]  SEG_BLANK  = 7'h00;
    localparam logic [6:0]  SEG_DASH   = 7'h40;

    function automatic logic [6:0] seg_code(input logic [3:0] digit);
        logic [6:0] code;
        case (digit)
            4'd0:    code = 7'h3F;
            4'd1:    code = 7'h06;
            4'd2:    code = 7'h5B;
            4'd3:    code = 7'h4F;
            4'd4:    code = 7'h66;
            4'd5:    code = 7'h6D;
            4'd6:    code = 7'h7D;
            4'd7:    code = 7'h07;
            4'd8:    code = 7'h7F;
            4'd9:    code = 7'h6F;
            default: code = SEG_BLANK;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: 14-bit binary to 5 BCD digits in 14 steps.
module bin2bcd_seq
    import seg7_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [13:0] bin_in,
    output logic        busy,
    output logic        done,
    output logic [19:0] bcd_out
);

    logic [13:0] sr;
    logic [19:0] acc;
    logic [19:0] adj;
    logic [3:0]  cnt;
    logic        run;

    always_comb begin
        adj = acc;
        for (int unsigned i = 0; i < BCD_DIGITS; i++) begin
            if (acc[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run <= 1'b0;
            sr  <= '0;
            acc <= '0;
            cnt <= '0;
        end else if (start && !run) begin
            run <= 1'b1;
            sr  <= bin_in;
            acc <= '0;
            cnt <= '0;
        end else if (run) begin
            acc <= {adj[18:0], sr[13]};
            sr  <= {sr[12:0], 1'b0};
            cnt <= cnt + 4'd1;
            if (cnt == 4'd13)
                run <= 1'b0;
        end
    end

    // done marks the cycle whose closing edge applies the final step,
    // so the caller can sample bcd_out on the very next cycle.
    assign busy    = run;
    assign done    = run && (cnt == 4'd13);
    assign bcd_out = acc;

endmodule

// File: rtl/seg7_display_driver.sv
// Four-digit multiplexed 7-segment driver with blanking and overflow dashes.
// Optional SIGNED_DISPLAY_EN treats value_in as two's complement with a minus sign.
module seg7_display_driver
    import seg7_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 1024,
    parameter int unsigned VALUE_W     = 14
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [VALUE_W-1:0] value_in,
    output logic [6:0]         seg_out,
    output logic [3:0]         dig_sel,
    output logic               busy,
    output logic               overflow
);

    localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

    state_t             state;
    logic [VALUE_W-1:0] last_value;
    logic [6:0]         disp_seg [4];
    logic [6:0]         next_seg [4];
    logic               next_ovf;
    logic [CNT_W-1:0]   ref_cnt;
    logic [1:0]         dig_idx;
    logic               start;
    logic [13:0]        conv_in;
    logic               conv_busy;
    logic               conv_done;
    logic [19:0]        bcd;
    logic [3:0]         d [BCD_DIGITS];
    logic [1:0]         msd;

    assign start = (state == ST_IDLE) && (value_in != last_value);
    assign busy  = conv_busy || (state == ST_UPDATE);

`ifdef SIGNED_DISPLAY_EN
    logic neg_q;
    assign conv_in = value_in[13] ? (~value_in + 14'd1) : value_in;
`else
    assign conv_in = value_in;
`endif

    bin2bcd_seq u_bcd (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .bin_in  (conv_in),
        .busy    (conv_busy),
        .done    (conv_done),
        .bcd_out (bcd)
    );

    always_comb begin
        for (int unsigned i = 0; i < BCD_DIGITS; i++)
            d[i] = bcd[4*i +: 4];
        msd = 2'd0;
        if (d[1] != 4'd0) msd = 2'd1;
        if (d[2] != 4'd0) msd = 2'd2;
        if (d[3] != 4'd0) msd = 2'd3;
`ifdef SIGNED_DISPLAY_EN
        next_ovf = neg_q ? ((d[4] != 4'd0) || (d[3] != 4'd0)) : (d[4] != 4'd0);
`else
        next_ovf = (d[4] != 4'd0);
`endif
        for (int unsigned i = 0; i < 4; i++) begin
            if (next_ovf)
                next_seg[i] = SEG_DASH;
            else if (i <= 32'(msd))
                next_seg[i] = seg_code(d[i]);
`ifdef SIGNED_DISPLAY_EN
            else if (neg_q && (i == 32'(msd) + 1))
                next_seg[i] = SEG_DASH;
`endif
            else
                next_seg[i] = SEG_BLANK;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            last_value  <= '0;
            overflow    <= 1'b0;
            disp_seg[0] <= seg_code(4'd0);
            disp_seg[1] <= SEG_BLANK;
            disp_seg[2] <= SEG_BLANK;
            disp_seg[3] <= SEG_BLANK;
`ifdef SIGNED_DISPLAY_EN
            neg_q       <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        last_value <= value_in;
`ifdef SIGNED_DISPLAY_EN
                        neg_q      <= value_in[13];
`endif
                        state      <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (conv_done)
                        state <= ST_UPDATE;
                end
                ST_UPDATE: begin
                    for (int unsigned i = 0; i < 4; i++)
                        disp_seg[i] <= next_seg[i];
                    overflow <= next_ovf;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ref_cnt <= '0;
            dig_idx <= 2'd0;
            seg_out <= 7'h3F;
            dig_sel <= 4'b0001;
        end else begin
            if (ref_cnt == CNT_MAX) begin
                ref_cnt <= '0;
                dig_idx <= dig_idx + 2'd1;
            end else begin
                ref_cnt <= ref_cnt + 1'b1;
            end
            dig_sel <= 4'b0001 << dig_idx;
            seg_out <= disp_seg[dig_idx];
        end
    end

endmodule

// File: tb/tb_seg7_display_driver.sv
// Directed self-checking bench for seg7_display_driver with REFRESH_DIV=4.
module tb_seg7_display_driver;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [13:0] value_in = '0;
    logic [6:0]  seg_out;
    logic [3:0]  dig_sel;
    logic        busy;
    logic        overflow;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    seg7_display_driver #(.REFRESH_DIV(4), .VALUE_W(14)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .value_in (value_in),
        .seg_out  (seg_out),
        .dig_sel  (dig_sel),
        .busy     (busy),
        .overflow (overflow)
    );

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for the requested digit to be enabled, then compares its segments.
    task automatic check_digit(input int pos, input logic [6:0] exp, input string tag);
        logic [3:0] onehot;
        int n;
        onehot = 4'b0001;
        onehot = onehot << pos;
        n = 0;
        while (dig_sel !== onehot && n < 40) begin
            step(1);
            n++;
        end
        check(tag, {21'd0, dig_sel, seg_out}, {21'd0, onehot, exp});
    endtask

    task automatic scan(input logic [6:0] e3, input logic [6:0] e2,
                        input logic [6:0] e1, input logic [6:0] e0, input string tag);
        step(1);
        check_digit(0, e0, {tag, "_units"});
        check_digit(1, e1, {tag, "_tens"});
        check_digit(2, e2, {tag, "_hundreds"});
        check_digit(3, e3, {tag, "_thousands"});
    endtask

    task automatic convert(input logic [13:0] v, input string tag);
        value_in = v;
        step(16);
        check({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        step(3);
        rst_n = 1'b1;
        check("rst_dig_sel", {28'd0, dig_sel}, 32'h1);
        check("rst_seg", {25'd0, seg_out}, 32'h3F);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_ovf", {31'd0, overflow}, 32'd0);

        step(4);
        check("ref_e4", {28'd0, dig_sel}, 32'h1);
        step(1);
        check("ref_e5", {21'd0, dig_sel, seg_out}, {21'd0, 4'b0010, 7'h00});
        step(4);
        check("ref_e9", {21'd0, dig_sel, seg_out}, {21'd0, 4'b0100, 7'h00});
        step(4);
        check("ref_e13", {21'd0, dig_sel, seg_out}, {21'd0, 4'b1000, 7'h00});
        step(4);
        check("ref_e17", {21'd0, dig_sel, seg_out}, {21'd0, 4'b0001, 7'h3F});

        value_in = 14'd1234;
        step(1);
        check("c1234_busy_t0", {31'd0, busy}, 32'd1);
        step(14);
        check("c1234_busy_t14", {31'd0, busy}, 32'd1);
        step(1);
        check("c1234_busy_t15", {31'd0, busy}, 32'd0);
        check("c1234_ovf", {31'd0, overflow}, 32'd0);
        scan(7'h06, 7'h5B, 7'h4F, 7'h66, "v1234");

        convert(14'd7, "v7");
        scan(7'h00, 7'h00, 7'h00, 7'h07, "v7");
        convert(14'd0, "v0");
        scan(7'h00, 7'h00, 7'h00, 7'h3F, "v0");
        convert(14'd305, "v305");
        scan(7'h00, 7'h4F, 7'h3F, 7'h6D, "v305");

        value_in = 14'd55;
        step(5);
        value_in = 14'd66;
        step(11);
        check("chg_busy_t15", {31'd0, busy}, 32'd0);
        step(1);
        check("chg_busy_t16", {31'd0, busy}, 32'd1);
        step(15);
        check("chg_busy_t31", {31'd0, busy}, 32'd0);
        scan(7'h00, 7'h00, 7'h7D, 7'h7D, "v66");

`ifdef SIGNED_DISPLAY_EN
        convert(14'h3FFB, "neg5");
        check("neg5_ovf", {31'd0, overflow}, 32'd0);
        scan(7'h00, 7'h00, 7'h40, 7'h6D, "neg5");
        convert(14'h3C19, "neg999");
        check("neg999_ovf", {31'd0, overflow}, 32'd0);
        scan(7'h40, 7'h6F, 7'h6F, 7'h6F, "neg999");
        convert(14'h3C18, "neg1000");
        check("neg1000_ovf", {31'd0, overflow}, 32'd1);
        scan(7'h40, 7'h40, 7'h40, 7'h40, "neg1000");
`else
        convert(14'd10000, "v10000");
        check("v10000_ovf", {31'd0, overflow}, 32'd1);
        scan(7'h40, 7'h40, 7'h40, 7'h40, "v10000");
        convert(14'd9999, "v9999");
        check("v9999_ovf", {31'd0, overflow}, 32'd0);
        scan(7'h6F, 7'h6F, 7'h6F, 7'h6F, "v9999");
        convert(14'd16383, "v16383");
        check("v16383_ovf", {31'd0, overflow}, 32'd1);
`endif

        value_in = 14'd4321;
        step(8);
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_ovf", {31'd0, overflow}, 32'd0);
        value_in = 14'd0;
        scan(7'h00, 7'h00, 7'h00, 7'h3F, "abort");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
